pcs_40g_rx_block_sync: RTL and testbench

Receive-side counterpart of the 40G PCS transmit gearbox. It takes the 16-bit PMA word stream, reassembles 66-bit blocks, and runs the 64b/66b block-lock state machine with bit-slip. Its outputs are the 2-bit sync header, the 64-bit scrambled payload and lock status, which feed the downstream alignment-marker removal, descrambler and decoder stages.

---
 rtl/pcs_40g_rx_block_sync.sv | 170 +++++++++++++++++
 tb/tb_pcs_40g_rx_block_sync.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_40g_rx_block_sync.sv
// 40G PCS receive block sync: regroups 16-bit PMA words into 66-bit blocks
// and runs the 64b/66b block-lock state machine, which slips one bit at a
// time until the sync headers line up.
module pcs_40g_rx_block_sync #(
  parameter int PMA_DATA_W = 16,
  parameter int DATA_W     = 64,
  parameter int LOCK_CNT   = 64,
  parameter int INVLD_MAX  = 16
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [PMA_DATA_W-1:0] pma_i,
  output logic [1:0]            head_o,
  output logic [DATA_W-1:0]     data_o,
  output logic                  valid_o,
  output logic                  lock_o,
  output logic                  slip_o
);

  localparam int BLK_W = DATA_W + 2;
  // The fill level never exceeds BLK_W-1 before an append, so one block
  // less a bit plus one PMA word is the deepest the buffer can get.
  localparam int BUF_W = BLK_W - 1 + PMA_DATA_W;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int SH_W  = $clog2(LOCK_CNT) + 1;
  localparam int INV_W = $clog2(INVLD_MAX) + 1;

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  // A sync header is legal only when its two bits differ (01 or 10).
  function automatic logic hdr_valid(input logic [1:0] hdr);
    return hdr[0] ^ hdr[1];
  endfunction

  logic [BUF_W-1:0]  buf_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        head_r;
  logic [DATA_W-1:0] data_r;
  logic              valid_r;
  logic              lock_r;
  logic              slip_r;
  state_t            state_r;
  logic [SH_W-1:0]   sh_cnt_r;
  logic [INV_W-1:0]  inv_cnt_r;
  logic              slip_hold_r;

  logic [BUF_W-1:0]  app_s;
  logic [CNT_W-1:0]  next_cnt_s;
  logic              emit_s;
  logic [CNT_W-1:0]  shift_s;
  logic [BUF_W-1:0]  buf_nxt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  state_t            state_nxt_s;
  logic [SH_W-1:0]   sh_cnt_nxt_s;
  logic [INV_W-1:0]  inv_cnt_nxt_s;
  logic              slip_hold_nxt_s;
  logic              slip_s;
  logic              hdr_ok_s;

  // Gearbox: append the new word above the valid bits, then drop one block
  // and/or the slipped bit from the bottom in the same update.
  always_comb begin
    app_s      = buf_r | (BUF_W'(pma_i) << cnt_r);
    next_cnt_s = cnt_r + CNT_W'(PMA_DATA_W);
    emit_s     = (next_cnt_s >= CNT_W'(BLK_W));
    shift_s    = (emit_s ? CNT_W'(BLK_W) : {CNT_W{1'b0}}) +
                 (slip_s ? CNT_W'(1) : {CNT_W{1'b0}});
    buf_nxt_s  = app_s >> shift_s;
    cnt_nxt_s  = next_cnt_s - shift_s;
  end

  // Lock FSM: judges the header of the block currently on the outputs.
  // slip_hold_r blocks a second slip on the first block examined after one.
  always_comb begin
    state_nxt_s     = state_r;
    sh_cnt_nxt_s    = sh_cnt_r;
    inv_cnt_nxt_s   = inv_cnt_r;
    slip_hold_nxt_s = slip_hold_r;
    slip_s          = 1'b0;
    hdr_ok_s        = hdr_valid(head_r);
    if (valid_r) begin
      slip_hold_nxt_s = 1'b0;
      case (state_r)
        ST_UNLOCKED: begin
          if (hdr_ok_s) begin
            if (sh_cnt_r == SH_W'(LOCK_CNT - 1)) begin
              state_nxt_s   = ST_LOCKED;
              sh_cnt_nxt_s  = {SH_W{1'b0}};
              inv_cnt_nxt_s = {INV_W{1'b0}};
            end else begin
              sh_cnt_nxt_s  = sh_cnt_r + SH_W'(1);
            end
          end else begin
            sh_cnt_nxt_s = {SH_W{1'b0}};
            slip_s       = ~slip_hold_r;
          end
        end
        ST_LOCKED: begin
          // Loss of lock is checked first so it wins over a window wrap.
          if (!hdr_ok_s && (inv_cnt_r == INV_W'(INVLD_MAX - 1))) begin
            state_nxt_s   = ST_UNLOCKED;
            sh_cnt_nxt_s  = {SH_W{1'b0}};
            inv_cnt_nxt_s = {INV_W{1'b0}};
            slip_s        = ~slip_hold_r;
          end else if (sh_cnt_r == SH_W'(LOCK_CNT - 1)) begin
            sh_cnt_nxt_s  = {SH_W{1'b0}};
            inv_cnt_nxt_s = {INV_W{1'b0}};
          end else begin
            sh_cnt_nxt_s  = sh_cnt_r + SH_W'(1);
            inv_cnt_nxt_s = hdr_ok_s ? inv_cnt_r : (inv_cnt_r + INV_W'(1));
          end
        end
        default: begin
          state_nxt_s   = ST_UNLOCKED;
          sh_cnt_nxt_s  = {SH_W{1'b0}};
          inv_cnt_nxt_s = {INV_W{1'b0}};
        end
      endcase
      if (slip_s) begin
        slip_hold_nxt_s = 1'b1;
      end else begin
        slip_hold_nxt_s = slip_hold_nxt_s;
      end
    end else begin
      slip_hold_nxt_s = slip_hold_r;
    end
  end

  // State and output registers; lock_o and slip_o change together on the
  // edge that applies the FSM decision.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      buf_r       <= {BUF_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      head_r      <= 2'b00;
      data_r      <= {DATA_W{1'b0}};
      valid_r     <= 1'b0;
      lock_r      <= 1'b0;
      slip_r      <= 1'b0;
      state_r     <= ST_UNLOCKED;
      sh_cnt_r    <= {SH_W{1'b0}};
      inv_cnt_r   <= {INV_W{1'b0}};
      slip_hold_r <= 1'b0;
    end else begin
      buf_r       <= buf_nxt_s;
      cnt_r       <= cnt_nxt_s;
      valid_r     <= emit_s;
      if (emit_s) begin
        head_r <= app_s[1:0];
        data_r <= app_s[BLK_W-1:2];
      end
      state_r     <= state_nxt_s;
      lock_r      <= (state_nxt_s == ST_LOCKED);
      slip_r      <= slip_s;
      sh_cnt_r    <= sh_cnt_nxt_s;
      inv_cnt_r   <= inv_cnt_nxt_s;
      slip_hold_r <= slip_hold_nxt_s;
    end
  end

  assign head_o  = head_r;
  assign data_o  = data_r;
  assign valid_o = valid_r;
  assign lock_o  = lock_r;
  assign slip_o  = slip_r;

endmodule

// File: tb/tb_pcs_40g_rx_block_sync.sv
// Self-checking bench for pcs_40g_rx_block_sync: a reset/fill vector table,
// then bit-stream runs checked every cycle against a queue-based model.
module tb_pcs_40g_rx_block_sync;

  localparam logic [63:0] PAYLOAD = 64'hDEAD_BEEF_0123_4567;

  logic        clk = 1'b0;
  logic        nreset;
  logic [15:0] pma_i;
  logic [1:0]  head_o;
  logic [63:0] data_o;
  logic        valid_o, lock_o, slip_o;

  always #5 clk = ~clk;

  pcs_40g_rx_block_sync dut (
    .clk(clk), .nreset(nreset), .pma_i(pma_i), .head_o(head_o),
    .data_o(data_o), .valid_o(valid_o), .lock_o(lock_o), .slip_o(slip_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus bit source ----------------
  bit          tx_q[$];
  logic [65:0] sent_q[$];
  bit          bad_blk[512];

  task automatic push_block(input logic [1:0] h, input logic [63:0] d);
    for (int i = 0; i < 2; i++) tx_q.push_back(h[i]);
    for (int i = 0; i < 64; i++) tx_q.push_back(d[i]);
    sent_q.push_back({d, h});
  endtask

  task automatic push_random_block();
    logic [1:0]  h;
    logic [63:0] d;
    h = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    d = {$urandom, $urandom};
    push_block(h, d);
  endtask

  // ---------------- reference model ----------------
  // Bits go into a FIFO; every 66 bits form a block. Lock rules are applied
  // to the block currently presented, and a slip discards one FIFO bit.
  bit          mq[$];
  logic        m_valid, m_lock, m_slip;
  logic [1:0]  m_head;
  logic [63:0] m_data;
  int          m_sh, m_inv;
  bit          m_locked, m_noslip;

  task automatic model_step(input logic rn, input logic [15:0] w);
    bit          ok, blocked, slip;
    logic [65:0] b;
    if (!rn) begin
      mq.delete();
      m_valid = 0; m_lock = 0; m_slip = 0; m_head = 2'b00; m_data = 64'd0;
      m_sh = 0; m_inv = 0; m_locked = 0; m_noslip = 0;
    end else begin
      slip = 0;
      if (m_valid) begin
        ok = (m_head == 2'b01) || (m_head == 2'b10);
        blocked = m_noslip;
        m_noslip = 0;
        if (!m_locked) begin
          if (ok) begin
            m_sh++;
            if (m_sh == 64) begin m_locked = 1; m_sh = 0; m_inv = 0; end
          end else begin
            m_sh = 0;
            slip = !blocked;
          end
        end else begin
          m_sh++;
          if (!ok) m_inv++;
          if (m_inv == 16) begin m_locked = 0; m_sh = 0; m_inv = 0; slip = !blocked; end
          else if (m_sh == 64) begin m_sh = 0; m_inv = 0; end
        end
        if (slip) m_noslip = 1;
      end
      for (int i = 0; i < 16; i++) mq.push_back(w[i]);
      m_valid = 0;
      if (mq.size() >= 66) begin
        for (int i = 0; i < 66; i++) b[i] = mq.pop_front();
        m_head = b[1:0];
        m_data = b[65:2];
        m_valid = 1;
      end
      if (slip) void'(mq.pop_front());
      m_slip = slip;
      m_lock = m_locked;
    end
  endtask

  // ---------------- run statistics ----------------
  int   cyc, n_valid, n_slip, n_rise, n_fall, vss, v64_cyc, rise_cyc, fall_cyc;
  int   inv_seen, inv_at_fall, last_inv_cyc;
  logic slip_at_fall, prev_lock;
  bit   chk_payload, track_sent, aligned;

  task automatic stats_clear();
    cyc = 0; n_valid = 0; n_slip = 0; n_rise = 0; n_fall = 0; vss = 0;
    v64_cyc = -10; rise_cyc = -20; fall_cyc = -30; inv_seen = 0;
    inv_at_fall = 0; last_inv_cyc = -40; slip_at_fall = 0; prev_lock = 0;
    chk_payload = 0; track_sent = 0; aligned = 0;
  endtask

  // One clock: drive, clock, advance model, compare, gather statistics.
  task automatic cycle(input logic rn);
    logic [15:0] w;
    bit          found;
    if (tx_q.size() >= 16) begin
      for (int i = 0; i < 16; i++) w[i] = tx_q.pop_front();
    end else begin
      w = 16'($urandom);
    end
    nreset = rn;
    pma_i  = w;
    @(posedge clk);
    model_step(rn, w);
    #1;
    chk("valid_o", 66'(valid_o), 66'(m_valid));
    chk("lock_o",  66'(lock_o),  66'(m_lock));
    chk("slip_o",  66'(slip_o),  66'(m_slip));
    chk("head_o",  66'(head_o),  66'(m_head));
    chk("data_o",  66'(data_o),  66'(m_data));
    cyc++;
    if (!rn) vss = 0;
    if (slip_o) begin n_slip++; vss = 0; end
    if (valid_o) begin
      n_valid++;
      vss++;
      if (vss == 64) v64_cyc = cyc;
      if (lock_o && !((head_o == 2'b01) || (head_o == 2'b10))) begin
        inv_seen++;
        last_inv_cyc = cyc;
      end
      if (chk_payload && lock_o) chk("payload", {data_o, head_o}, {PAYLOAD, 2'b01});
      if (track_sent && lock_o) begin
        if (!aligned) begin
          while (sent_q.size() > 0 && sent_q[0] != {data_o, head_o}) void'(sent_q.pop_front());
          found = (sent_q.size() > 0);
          chk("align_found", 66'(found), 66'(1));
          if (found) void'(sent_q.pop_front());
          aligned = 1;
        end else if (sent_q.size() > 0) begin
          chk("block_order", {data_o, head_o}, sent_q.pop_front());
        end
      end
    end
    if (lock_o && !prev_lock) begin n_rise++; rise_cyc = cyc; inv_seen = 0; end
    if (!lock_o && prev_lock) begin
      n_fall++; fall_cyc = cyc; inv_at_fall = inv_seen; slip_at_fall = slip_o;
    end
    prev_lock = lock_o;
  endtask

  task automatic run_reset();
    tx_q.delete();
    sent_q.delete();
    stats_clear();
    repeat (3) cycle(1'b0);
  endtask

  task automatic run_const();
    run_reset();
    for (int k = 0; k < 200; k++) push_block(bad_blk[k] ? 2'b00 : 2'b01, PAYLOAD);
    repeat (825) cycle(1'b1);
  endtask

  task automatic clear_bad();
    for (int k = 0; k < 512; k++) bad_blk[k] = 0;
  endtask

  // ---------------- vector table for reset and first fill ----------------
  typedef struct {
    logic        rn;
    logic [15:0] w;
    logic        ev;
    logic [1:0]  eh;
    logic [63:0] ed;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int v_a, v_b;
    nreset = 1'b0;
    pma_i  = 16'h0000;

    vecs[0] = '{1'b0, 16'($urandom), 1'b0, 2'b00, 64'd0};
    vecs[1] = '{1'b0, 16'($urandom), 1'b0, 2'b00, 64'd0};
    vecs[2] = '{1'b0, 16'($urandom), 1'b0, 2'b00, 64'd0};
    vecs[3] = '{1'b1, 16'h1235, 1'b0, 2'b00, 64'd0};
    vecs[4] = '{1'b1, 16'h4567, 1'b0, 2'b00, 64'd0};
    vecs[5] = '{1'b1, 16'h89AB, 1'b0, 2'b00, 64'd0};
    vecs[6] = '{1'b1, 16'hCDEF, 1'b0, 2'b00, 64'd0};
    vecs[7] = '{1'b1, 16'h0002, 1'b1, 2'b01,
                {2'b10, 16'hCDEF, 16'h89AB, 16'h4567, 14'h048D}};
    vecs[8] = '{1'b1, 16'hFFFF, 1'b0, 2'b01,
                {2'b10, 16'hCDEF, 16'h89AB, 16'h4567, 14'h048D}};

    // Reset hold and first fill: first block appears after the 5th word.
    for (int i = 0; i < 9; i++) begin
      nreset = vecs[i].rn;
      pma_i  = vecs[i].w;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 66'(valid_o), 66'(vecs[i].ev));
      chk($sformatf("tbl%0d_lock", i),  66'(lock_o),  66'(1'b0));
      chk($sformatf("tbl%0d_slip", i),  66'(slip_o),  66'(1'b0));
      chk($sformatf("tbl%0d_head", i),  66'(head_o),  66'(vecs[i].eh));
      chk($sformatf("tbl%0d_data", i),  66'(data_o),  66'(vecs[i].ed));
    end

    // Aligned constant stream: no slips, lock after 64th block, 32 per 132.
    clear_bad();
    run_reset();
    chk_payload = 1;
    for (int k = 0; k < 200; k++) push_block(2'b01, PAYLOAD);
    v_a = 0; v_b = 0;
    for (int i = 0; i < 825; i++) begin
      cycle(1'b1);
      if (i == 299) v_a = n_valid;
      if (i == 431) v_b = n_valid;
    end
    chk("t2_slips", 66'(n_slip), 66'(0));
    chk("t2_rises", 66'(n_rise), 66'(1));
    chk("t2_lock_at", 66'(rise_cyc), 66'(v64_cyc + 1));
    chk("t2_rate", 66'(v_b - v_a), 66'(32));
    chk("t2_lock_end", 66'(lock_o), 66'(1));

    // 15 invalid headers in one window: lock holds.
    clear_bad();
    for (int i = 0; i < 15; i++) bad_blk[64 + 4 * i] = 1;
    run_const();
    chk("t4a_falls", 66'(n_fall), 66'(0));

    // 16 invalid headers in one window: lock drops with a slip.
    clear_bad();
    for (int i = 0; i < 16; i++) bad_blk[64 + 3 * i] = 1;
    run_const();
    chk("t4b_falls", 66'(n_fall), 66'(1));
    chk("t4b_inv_cnt", 66'(inv_at_fall), 66'(16));
    chk("t4b_fall_at", 66'(fall_cyc), 66'(last_inv_cyc + 1));
    chk("t4b_slip_at_fall", 66'(slip_at_fall), 66'(1));

    // 16th invalid is also the 64th block of the window: loss of lock wins.
    clear_bad();
    for (int i = 0; i < 16; i++) bad_blk[112 + i] = 1;
    run_const();
    chk("t4c_falls", 66'(n_fall), 66'(1));
    chk("t4c_inv_cnt", 66'(inv_at_fall), 66'(16));
    chk("t4c_fall_at", 66'(fall_cyc), 66'(last_inv_cyc + 1));

    // 15 invalid in each of two consecutive windows: lock holds.
    clear_bad();
    for (int i = 0; i < 15; i++) begin
      bad_blk[64 + 4 * i]  = 1;
      bad_blk[128 + 4 * i] = 1;
    end
    run_const();
    chk("t5_falls", 66'(n_fall), 66'(0));
    chk("t5_lock_end", 66'(lock_o), 66'(1));

    // Random blocks behind 5 garbage bits: slip into alignment and lock.
    run_reset();
    track_sent = 1;
    for (int i = 0; i < 5; i++) tx_q.push_back(1'($urandom));
    for (int k = 0; k < 150; k++) push_random_block();
    repeat (615) cycle(1'b1);
    chk("t3_slip_range", 66'((n_slip >= 1) && (n_slip <= 66)), 66'(1));
    chk("t3_rises", 66'(n_rise), 66'(1));
    chk("t3_lock_at", 66'(rise_cyc), 66'(v64_cyc + 1));
    chk("t3_aligned", 66'(aligned), 66'(1));

    // Reset pulse while locked: lock drops next cycle and relocks.
    run_reset();
    for (int k = 0; k < 500; k++) push_random_block();
    for (int i = 0; i < 1500 && !lock_o; i++) cycle(1'b1);
    chk("t6_lock_wait1", 66'(lock_o), 66'(1));
    repeat (50) cycle(1'b1);
    cycle(1'b0);
    chk("t6_lock_after_rst", 66'(lock_o), 66'(0));
    for (int i = 0; i < 1500 && !lock_o; i++) cycle(1'b1);
    chk("t6_lock_wait2", 66'(lock_o), 66'(1));
    chk("t6_rises", 66'(n_rise), 66'(2));
    chk("t6_relock_at", 66'(rise_cyc), 66'(v64_cyc + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
